// File: rtl/sram_arbiter.sv
// Round-robin two-port controller for the 16-bit asynchronous SRAM.
// Strobes are registered from the next state so the pins change exactly on state entry.
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_be,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_be,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              bus_oe,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_HOLD, RD_DONE, WR_SETUP, WR_PULSE, WR_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic              last_grant_reg, last_grant_next;
    logic              grant_reg, grant_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [1:0]        be_reg, be_next;

    logic [ADDR_W-1:0] sram_addr_reg, sram_addr_next;
    logic              ce_n_reg, ce_n_next;
    logic              oe_n_reg, oe_n_next;
    logic              we_n_reg, we_n_next;
    logic              ub_n_reg, ub_n_next;
    logic              lb_n_reg, lb_n_next;
    logic              bus_oe_reg, bus_oe_next;
    logic [DATA_W-1:0] bus_wdata_reg, bus_wdata_next;
    logic [1:0]        ack_reg, ack_next;

    // On a tie the port that did not win last time is served.
    logic              grant_sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_be;

    assign grant_sel = (p0_req & p1_req) ? ~last_grant_reg : p1_req;
    assign sel_we    = grant_sel ? p1_we    : p0_we;
    assign sel_addr  = grant_sel ? p1_addr  : p0_addr;
    assign sel_wdata = grant_sel ? p1_wdata : p0_wdata;
    assign sel_be    = grant_sel ? p1_be    : p0_be;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            be_reg         <= '0;
            sram_addr_reg  <= '0;
            ce_n_reg       <= 1'b1;
            oe_n_reg       <= 1'b1;
            we_n_reg       <= 1'b1;
            ub_n_reg       <= 1'b1;
            lb_n_reg       <= 1'b1;
            bus_oe_reg     <= 1'b0;
            bus_wdata_reg  <= '0;
            ack_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            be_reg         <= be_next;
            sram_addr_reg  <= sram_addr_next;
            ce_n_reg       <= ce_n_next;
            oe_n_reg       <= oe_n_next;
            we_n_reg       <= we_n_next;
            ub_n_reg       <= ub_n_next;
            lb_n_reg       <= lb_n_next;
            bus_oe_reg     <= bus_oe_next;
            bus_wdata_reg  <= bus_wdata_next;
            ack_reg        <= ack_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = wait_cnt_reg;
        last_grant_next = last_grant_reg;
        grant_next      = grant_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        be_next         = be_reg;
        case (state_reg)
            IDLE: begin
                if (p0_req | p1_req) begin
                    grant_next      = grant_sel;
                    last_grant_next = grant_sel;
                    addr_next       = sel_addr;
                    wdata_next      = sel_wdata;
                    be_next         = sel_be;
                    state_next      = sel_we ? WR_SETUP : RD_SETUP;
                end
            end
            RD_SETUP: begin
                state_next    = RD_HOLD;
                wait_cnt_next = HOLD_INIT;
            end
            RD_HOLD: begin
                if (wait_cnt_reg == '0) state_next = RD_DONE;
                else wait_cnt_next = wait_cnt_reg - CNT_W'(1);
            end
            WR_SETUP: begin
                state_next    = WR_PULSE;
                wait_cnt_next = HOLD_INIT;
            end
            WR_PULSE: begin
                if (wait_cnt_reg == '0) state_next = WR_DONE;
                else wait_cnt_next = wait_cnt_reg - CNT_W'(1);
            end
            RD_DONE, WR_DONE: state_next = IDLE;
            default:          state_next = IDLE;
        endcase
    end

    // Pin values for the state being entered; the access fields come from the
    // next-state values so a fresh grant already shows its address in SETUP.
    always_comb begin
        sram_addr_next = sram_addr_reg;
        ce_n_next      = 1'b1;
        oe_n_next      = 1'b1;
        we_n_next      = 1'b1;
        ub_n_next      = 1'b1;
        lb_n_next      = 1'b1;
        bus_oe_next    = 1'b0;
        bus_wdata_next = bus_wdata_reg;
        ack_next       = '0;
        case (state_next)
            RD_SETUP, RD_HOLD: begin
                sram_addr_next = addr_next;
                ce_n_next      = 1'b0;
                oe_n_next      = 1'b0;
                ub_n_next      = ~be_next[1];
                lb_n_next      = ~be_next[0];
            end
            RD_DONE: ack_next[grant_next] = 1'b1;
            WR_SETUP, WR_PULSE: begin
                sram_addr_next = addr_next;
                ce_n_next      = 1'b0;
                we_n_next      = (state_next != WR_PULSE);
                ub_n_next      = ~be_next[1];
                lb_n_next      = ~be_next[0];
                bus_oe_next    = 1'b1;
                bus_wdata_next = wdata_next;
            end
            WR_DONE: begin
                ce_n_next   = 1'b0;
                ub_n_next   = ~be_next[1];
                lb_n_next   = ~be_next[0];
                bus_oe_next = 1'b1;
                ack_next[grant_next] = 1'b1;
            end
            default: ;
        endcase
    end

    // bus_rdata is valid during RD_DONE, so the ack cycle forwards it directly
    // and the per-port register keeps it until that port's next read.
    logic [1:0][DATA_W-1:0] rdata_out;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_W-1:0] rdata_reg;
        logic              capture;

        assign capture = (state_reg == RD_DONE) && (grant_reg == 1'(gi));

        always_ff @(posedge Clk) begin
            if (Reset)        rdata_reg <= '0;
            else if (capture) rdata_reg <= bus_rdata;
        end

        assign rdata_out[gi] = capture ? bus_rdata : rdata_reg;
    end

    assign p0_rdata  = rdata_out[0];
    assign p1_rdata  = rdata_out[1];
    assign p0_ack    = ack_reg[0];
    assign p1_ack    = ack_reg[1];
    assign SRAM_ADDR = sram_addr_reg;
    assign SRAM_CE_N = ce_n_reg;
    assign SRAM_OE_N = oe_n_reg;
    assign SRAM_WE_N = we_n_reg;
    assign SRAM_UB_N = ub_n_reg;
    assign SRAM_LB_N = lb_n_reg;
    assign bus_oe    = bus_oe_reg;
    assign bus_wdata = bus_wdata_reg;
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port SRAM access controller for the 16-bit off-chip SRAM. It arbitrates between port 0 (CPU/Mem2IO side) and port 1 (video/frame reader) using round-robin. It sequences the SRAM control strobes and drives the data-bus tristate buffer's output enable and write data. It collects read data from the buffer's registered read path, which lags the bus by one clock.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, SRAM data width
- WAIT_STATES, 1, cycles spent in RD_HOLD / WR_PULSE (legal 1..15)

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- p0_req, p1_req  in  1  access request; hold high with stable fields until ack
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_addr, p1_addr  in  ADDR_W  word address
- p0_wdata, p1_wdata  in  DATA_W  write data
- p0_be, p1_be  in  2  byte enables: [1] = upper byte, [0] = lower byte
- p0_ack, p1_ack  out  1  one-cycle completion pulse
- p0_rdata, p1_rdata  out  DATA_W  read data; valid in the ack cycle and held until that port's next read ack
- SRAM_ADDR  out  ADDR_W  SRAM address
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1  active-low SRAM strobes
- bus_oe  out  1  tristate output enable; 1 = drive the data bus
- bus_wdata  out  DATA_W  data the tristate drives when bus_oe = 1
- bus_rdata  in  DATA_W  tristate's registered bus sample (bus value of the previous cycle)

## Operation
- States: IDLE, RD_SETUP, RD_HOLD, RD_DONE, WR_SETUP, WR_PULSE, WR_DONE.
- Arbitration (IDLE only):
  - If exactly one req is high, that port is granted.
  - If both are high, the port not in last_grant is granted.
  - last_grant updates on every grant and resets to port 1, so port 0 wins the first tie.
  - On grant, addr, we, wdata and be are latched into internal registers. Later changes on the port are ignored until ack.
- Transitions:
  - IDLE → RD_SETUP (we = 0) or WR_SETUP (we = 1).
  - RD_SETUP → RD_HOLD.
  - RD_HOLD stays for WAIT_STATES cycles (down-counter), then → RD_DONE.
  - RD_DONE → IDLE.
  - The write path follows the same pattern: WR_SETUP → WR_PULSE (WAIT_STATES cycles) → WR_DONE → IDLE.
- Outputs are registered, Moore-style, from the next state:
  - IDLE: CE_N = OE_N = WE_N = UB_N = LB_N = 1; bus_oe = 0; SRAM_ADDR holds its last value.
  - RD_SETUP / RD_HOLD: CE_N = 0, OE_N = 0, WE_N = 1, UB_N = ~be[1], LB_N = ~be[0], bus_oe = 0.
  - RD_DONE: all strobes = 1; bus_rdata is copied into the granted port's rdata; its ack = 1. Bytes with be = 0 are returned as-is, with no masking.
  - WR_SETUP: CE_N = 0, OE_N = 1, WE_N = 1, byte strobes from be, bus_oe = 1, bus_wdata = latched wdata.
  - WR_PULSE: same as WR_SETUP but WE_N = 0.
  - WR_DONE: WE_N = 1, CE_N = 0, bus_oe = 1 (data hold past the WE rising edge); ack = 1.
- bus_oe = 1 only in WR_SETUP, WR_PULSE and WR_DONE. It must never be high together with OE_N = 0.
- be = 00 still runs a full access with both byte strobes high and still acks.
- A req that stays high after ack is treated as a new request in the following IDLE cycle.
- Reset, in any state including mid-access, next edge:
  - state = IDLE; all strobes = 1; bus_oe = 0; SRAM_ADDR = 0; bus_wdata = 0.
  - acks = 0; rdata = 0; last_grant = port 1; wait counter = 0.
  - A request in flight is dropped without ack.

## Timing
- A grant in cycle T (IDLE) produces ack in cycle T + 2 + WAIT_STATES, then IDLE at T + 3 + WAIT_STATES.
- Throughput is one access per 3 + WAIT_STATES cycles: 4 cycles at the default. Back-to-back accesses from either port keep this spacing.
- Read data path: the bus is sampled in the last RD_HOLD cycle and appears on bus_rdata in RD_DONE. This requires OE_N low for at least two edges before RD_DONE, which RD_SETUP plus RD_HOLD guarantees.
- Ack is exactly one cycle. At most one ack is high in any cycle.

## Test plan
- Single read:
  - Stimulus: model holds 0xBEEF at 0x00010; p0 read, be = 11.
  - Response: OE_N low for 2 cycles; p0_ack 3 cycles after grant; p0_rdata = 0xBEEF; bus_oe stays 0 throughout.
- Single write:
  - Stimulus: p1 write 0x1234 to 0xFFFFF, be = 01.
  - Response: WE_N low for exactly 1 cycle; LB_N = 0, UB_N = 1; bus_oe high for 3 cycles; model lower byte = 0x34, upper byte unchanged.
- Contention:
  - Stimulus: p0 and p1 requests held high continuously.
  - Response: grants alternate p0, p1, p0, p1; acks 4 cycles apart; no port is starved.
- WAIT_STATES = 3:
  - Stimulus: one read.
  - Response: ack at grant + 5; RD_HOLD lasts 3 cycles.
- Reset mid-write:
  - Stimulus: assert Reset during WR_PULSE.
  - Response: next cycle WE_N = 1, bus_oe = 0, no ack, rdata = 0; a subsequent p0/p1 tie grants p0 first.
- Hold-off:
  - Stimulus: change p0_addr after grant, before ack.
  - Response: SRAM_ADDR keeps the originally latched address for the whole access.
